// File: rtl/ami_port_merge.sv
// Two-port AMI request merger: round-robin arbitration into one registered
// request slot, with read responses steered back through an in-order route FIFO.
package ami_pkg;
  typedef struct packed {
    logic         valid;
    logic         isWrite;
    logic [63:0]  addr;
    logic [511:0] data;
    logic [63:0]  size;
  } AMIRequest;

  typedef struct packed {
    logic         valid;
    logic [511:0] data;
    logic [63:0]  size;
  } AMIResponse;
endpackage

module ami_port_merge
  import ami_pkg::*;
#(
  parameter int ROUTE_LOG_DEPTH = 6,
  parameter int ORPHAN_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  AMIRequest  [1:0]         up_reqs,
  output logic       [1:0]         up_req_grants,
  output AMIResponse [1:0]         up_resps,
  input  logic       [1:0]         up_resp_grants,
  output AMIRequest                dn_req,
  input  logic                     dn_req_grant,
  input  AMIResponse               dn_resp,
  output logic                     dn_resp_grant,
  output logic [ROUTE_LOG_DEPTH:0] outstanding,
  output logic [ORPHAN_W-1:0]      orphan_count
);

  localparam int unsigned DEPTH = 2 ** ROUTE_LOG_DEPTH;

  AMIRequest                  oreg;
  logic                       oreg_v;
  logic                       rr;
  logic                       route_mem [DEPTH];
  logic [ROUTE_LOG_DEPTH-1:0] wr_ptr;
  logic [ROUTE_LOG_DEPTH-1:0] rd_ptr;
  logic [ROUTE_LOG_DEPTH:0]   count;

  logic       load_en;
  logic       route_full;
  logic       route_empty;
  logic       head;
  logic [1:0] elig;
  logic       grant_any;
  logic       winner;
  logic       push;
  logic       pop;
  logic       orphan;

  assign outstanding = count;

  always_comb begin
    load_en     = !oreg_v || dn_req_grant;
    route_full  = (count == (ROUTE_LOG_DEPTH + 1)'(DEPTH));
    route_empty = (count == '0);
    head        = route_mem[rd_ptr];

    // Reads need a route slot; writes never produce a response so bypass the check.
    elig[0] = rst_n && up_reqs[0].valid && load_en && (up_reqs[0].isWrite || !route_full);
    elig[1] = rst_n && up_reqs[1].valid && load_en && (up_reqs[1].isWrite || !route_full);

    grant_any = |elig;
    winner    = (&elig) ? rr : elig[1];

    up_req_grants         = '0;
    up_req_grants[winner] = grant_any;

    push   = grant_any && !up_reqs[winner].isWrite;
    pop    = rst_n && dn_resp.valid && !route_empty && up_resp_grants[head];
    orphan = rst_n && dn_resp.valid && route_empty;

    dn_resp_grant = pop || orphan;

    dn_req       = oreg;
    dn_req.valid = oreg_v;

    up_resps[0]       = dn_resp;
    up_resps[0].valid = dn_resp.valid && !route_empty && (head == 1'b0);
    up_resps[1]       = dn_resp;
    up_resps[1].valid = dn_resp.valid && !route_empty && (head == 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg         <= '0;
      oreg_v       <= 1'b0;
      rr           <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      orphan_count <= '0;
    end else begin
      if (grant_any) begin
        oreg   <= up_reqs[winner];
        oreg_v <= 1'b1;
        rr     <= ~winner;
      end else if (dn_req_grant) begin
        oreg_v <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (orphan && (orphan_count != '1)) orphan_count <= orphan_count + 1'b1;
    end
  end

  // Route storage carries no reset; only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) route_mem[wr_ptr] <= winner;
  end

endmodule

// File: doc/ami_port_merge.md
# ami_port_merge

Merges the two AMI request ports driven by a dual-port traffic generator such as the memory-drive block onto one downstream AMI memory channel. The merged request is registered once, and arbitration between the ports is round-robin. Read responses come back on the single channel in order and are steered to the issuing port through an in-order route FIFO. The block sits between the traffic generator's `mem_reqs`/`mem_resps` ports and the memory controller port.

## Interface
- `ROUTE_LOG_DEPTH`, default 6: log2 of route FIFO depth, which is the maximum outstanding reads (64).
- `ORPHAN_W`, default 16: width of the orphan-response counter.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `up_reqs[1:0]`  in  AMIRequest  requests from the two upstream ports
- `up_req_grants[1:0]`  out  1  request accepted from port p this cycle
- `up_resps[1:0]`  out  AMIResponse  responses routed to port p
- `up_resp_grants[1:0]`  in  1  port p consumes its response
- `dn_req`  out  AMIRequest  merged request to the memory channel
- `dn_req_grant`  in  1  channel accepts `dn_req`
- `dn_resp`  in  AMIResponse  response from the channel
- `dn_resp_grant`  out  1  block consumes `dn_resp`
- `outstanding`  out  ROUTE_LOG_DEPTH+1  route FIFO occupancy
- `orphan_count`  out  ORPHAN_W  saturating count of dropped responses

## Operation
**Output register**
- One entry: `oreg` (full AMIRequest) plus `oreg_v`.
- `dn_req` = `oreg` with `.valid` = `oreg_v`.
- `load_en` = `!oreg_v || dn_req_grant`.

**Eligibility**
- Port p is eligible when `up_reqs[p].valid` && `load_en` && (`up_reqs[p].isWrite` || `!route_full`).
- Writes are never blocked by the route FIFO.

**Round-robin arbitration**
- Pointer `rr` (1 bit) names the preferred port.
- If both ports are eligible, the winner is `rr`; if one is eligible, that port wins.
- `up_req_grants[winner]` = 1; the other grant is 0.
- On a grant, `rr` <= ~winner.

**Load**
- On a grant, `oreg` <= winning request and `oreg_v` <= 1.
- If `dn_req_grant` and there is no winner, `oreg_v` <= 0.
- If the loaded request is a read, push the winner index into the route FIFO in the same cycle.

**Route FIFO**
- Depth 2^ROUTE_LOG_DEPTH.
- `route_full` when occupancy equals depth. No push while full, even if a pop occurs in the same cycle.

**Response steering**
- `head` = route FIFO output.
- `up_resps[p]` = `dn_resp` with `.valid` = `dn_resp.valid` && `!route_empty` && `head == p`.
- `dn_resp_grant` = `dn_resp.valid` && (`route_empty` || `up_resp_grants[head]`).
- Pop the FIFO when `dn_resp.valid` && `!route_empty` && `up_resp_grants[head]`.

**Orphan responses**
- A response arriving while `route_empty` is granted and dropped.
- `orphan_count` increments by 1 and saturates at all-ones.

**Occupancy**
- Simultaneous push and pop leaves `outstanding` unchanged.

## Timing
- **Reset values:** `oreg_v`=0, `oreg`=0, `rr`=0, route FIFO empty, `outstanding`=0, `orphan_count`=0.
- **Outputs under reset:** `up_req_grants`=0, `up_resps[*].valid`=0, `dn_req.valid`=0, `dn_resp_grant`=0.
- **Mid-operation reset:** asserting `rst_n` low clears all state immediately. In-flight responses that arrive after reset are counted as orphans.
- **Request latency:** a grant in cycle N gives `dn_req.valid` in cycle N+1.
- **Back-to-back issue:** with `dn_req_grant` held high, one request per cycle is sustained.
- **Request grants:** combinational from `up_reqs`, `dn_req_grant`, `rr` and `route_full`. Upstream holds its request until granted.
- **Response path:** combinational pass-through with zero latency. A stall on `up_resp_grants[head]` holds `dn_resp` un-granted, with no head-of-line bypass.
- **Occupancy bound:** `outstanding` never exceeds 2^ROUTE_LOG_DEPTH.

## Test plan
- **Single read:** after reset, port 0 read at addr 0x40 with `dn_req_grant`=1 → `up_req_grants[0]`=1 in cycle 0; `dn_req.valid`=1 with addr 0x40 in cycle 1; `outstanding`=1. Then a `dn_resp` carrying data 0xA5 → `up_resps[0].valid`=1 with data 0xA5, `up_resps[1].valid`=0; after `up_resp_grants[0]`, `outstanding`=0.
- **Alternation:** both ports hold 8 reads each, `dn_req_grant`=1 → grants alternate 0,1,0,1… across 16 consecutive cycles. 16 in-order responses are then routed to ports 0,1,0,1… with each port receiving 8.
- **Backpressure:** `dn_req_grant`=0 for 5 cycles with both ports valid → exactly one grant (port 0), then no grants; `dn_req` stays stable. On release, port 1 is granted in the same cycle.
- **Route full:** with ROUTE_LOG_DEPTH=2, issue 4 reads with no responses → `outstanding`=4; a 5th read is not granted, while a write on the other port is granted. One response pop → the read is granted the next cycle.
- **Orphans:** 3 responses with an empty route FIFO → `dn_resp_grant`=1 each cycle, no `up_resps` valid, `orphan_count`=3. With ORPHAN_W=2, 5 orphans → `orphan_count`=3 (saturated).
- **Response stall:** head=1 and `up_resp_grants[1]`=0 for 4 cycles → `dn_resp_grant`=0 and `outstanding` unchanged. Grant → pop, and `outstanding` decrements by 1.
